dll_lock_ctrl: RTL
==================

// Module: dll_lock_ctrl
// PURPOSE
//  Lock sequencer for the FMDLL phase detector (PD) loop. Generates the nested M/N
//  window counters that frame each PD comparison, and drives Reset_PD. Proposes and
//  applies the 10-bit delay-line code (Q/Q_next): binary search (SAR) first, then +/-1
//  tracking. Raises locked once the loop dithers around a stable code.
// PARAMETERS
//  QW        10  delay code width (Q, Q_next)
//  MW        2   width of M / M_counter
//  NW        4   width of N / N_counter
//  LOCK_CNT  4   consecutive direction alternations needed to assert locked
// PORTS
//  clk_ext    in  1   reference clock; the only clock
//  Reset_DLL  in  1   asynchronous, active-high reset
//  en         in  1   1 = run loop; 0 = return to IDLE, hold Q
//  M          in  MW  outer window length; 0 is treated as 1
//  N          in  NW  inner window length; 0 is treated as 1
//  COMP       in  1   registered PD result (1 = increase delay, 0 = decrease)
//  M_counter  out MW  outer count, 1..M
//  N_counter  out NW  inner count, 1..N
//  Reset_PD   out 1   PD reset, registered
//  Q          out QW  applied delay code
//  Q_next     out QW  candidate code under test
//  locked     out 1   lock indicator
// BEHAVIOUR
//  Reset: state=IDLE, M_counter=0, N_counter=0, Reset_PD=1, Q=0, Q_next=0,
//   locked=0, bit index b=QW-1, alternation count=0.
//  Window: in SAR/TRACK, N_counter counts 1..N. On N wrap, M_counter advances 1..M.
//   (M,N) -> (1,1). M and N are shadowed at each (1,1); mid-window changes take effect
//   at the next window. A window is M*N cycles.
//  Decision edge: the edge on which counters go (M,N)->(1,1) sets dec_pend. On the
//   next edge, COMP is valid (PD registers one cycle late). Q/Q_next update on that
//   edge. The window counters keep running, so one decision occurs per window.
//  FSM:
//   IDLE: counters held at 0, Reset_PD=1. en=1 -> PRST.
//   PRST: Reset_PD=1 for exactly 2 cycles, counters=0. Then -> SAR with Q=0,
//    b=QW-1, Q_next=1<<b, counters=(1,1), Reset_PD=0.
//   SAR: at each decision:
//    - COMP=1: Q<=Q_next. COMP=0: Q unchanged.
//    - If b>0: b<=b-1, Q_next<=Q'|(1<<(b-1)), where Q' is the updated Q.
//    - If b==0: -> TRACK with Q_next=Q'+1 (saturating).
//   TRACK: at each decision:
//    - COMP=1: Q<=Q+1, saturating at 2^QW-1.
//    - COMP=0: Q<=Q-1, saturating at 0.
//    - Q_next<=new Q +/-1 in the same direction, saturating.
//    - At saturation Q_next==Q, so the PD holds its state. Accepted; no error flag.
//  Lock:
//   - In TRACK, a decision whose direction differs from the previous one increments
//     alt_cnt. Same direction resets alt_cnt to 0.
//   - locked<=1 when alt_cnt reaches LOCK_CNT.
//   - locked<=0 after LOCK_CNT consecutive same-direction decisions, on leaving
//     TRACK, or on reset.
//  en=0 in any state: next edge -> IDLE, Q held, Q_next<=Q, locked<=0, Reset_PD=1.
//   en=1 again restarts through PRST and SAR from Q=0.
//  Simultaneous en fall and decision edge: en wins; no Q update.
//  Async reset mid-window: all state to reset values immediately; no partial update.
//  Output latency: all outputs registered; Q changes 1 cycle after the decision edge.
// STRUCTURE
//  dll_pkg holds:
//   - state typedef {IDLE, PRST, SAR, TRACK}
//   - QW/MW/NW defaults
//   - PRST_CYC=2
//  Sub-module dll_win_cnt: nested M/N counter with shadow registers, clear/enable
//   inputs and a wrap pulse output. It is reused by the calibration path.
//  The FSM, SAR/track datapath and lock counter stay in dll_lock_ctrl.
// TESTING
//  1. M=1,N=1, COMP tied 1, en=1 after reset:
//     - SAR keeps every bit, Q=1023 after 10 decisions.
//     - TRACK holds Q=1023 with Q_next=1023.
//  2. M=2,N=3, PD model with target code 600:
//     - SAR ends Q=600 (bits 9,6,4,3 set).
//     - Dither 600/601 in TRACK; locked=1 after 4 alternations.
//  3. Counter sequence, M=3,N=4:
//     - N_counter 1,2,3,4 repeats; M_counter steps 1..3 per 4 cycles.
//     - One decision every 12 cycles.
//  4. Write M=1 mid-window (was 3):
//     - Current window completes with 3.
//     - Next window is 1*N cycles.
//  5. Locked at Q=512, then force COMP=0 for 4 decisions:
//     - Q steps down to 508.
//     - locked drops on the 4th same-direction decision.
//  6. Reset_DLL pulse mid-SAR, and separately en=0 mid-TRACK:
//     - Reset: outputs at reset values asynchronously.
//     - en=0: IDLE next edge, Q held, Reset_PD=1, and PRST lasts 2 cycles on re-enable.

Source files
------------

// File: rtl/dll_pkg.sv
// Shared types and defaults for the FMDLL lock sequencer and its window counter.
package dll_pkg;

    localparam int QW_DEF       = 10;
    localparam int MW_DEF       = 2;
    localparam int NW_DEF       = 4;
    localparam int LOCK_CNT_DEF = 4;
    localparam int PRST_CYC     = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRST  = 2'd1,
        SAR   = 2'd2,
        TRACK = 2'd3
    } dll_state_t;

endpackage

// File: rtl/dll_win_cnt.sv
// Nested M/N window counter. Lengths are shadowed whenever the count (re)starts at (1,1);
// wrap is high during the cycle whose edge returns the counters from (M,N) to (1,1).
module dll_win_cnt #(
    parameter int MW = 2,
    parameter int NW = 4
) (
    input  logic          clk_ext,
    input  logic          rst,
    input  logic          clr,
    input  logic          run,
    input  logic [MW-1:0] m_len,
    input  logic [NW-1:0] n_len,
    output logic [MW-1:0] m_cnt,
    output logic [NW-1:0] n_cnt,
    output logic          wrap
);

    logic [MW-1:0] m_cnt_reg;
    logic [MW-1:0] m_sh_reg;
    logic [NW-1:0] n_cnt_reg;
    logic [NW-1:0] n_sh_reg;
    logic [MW-1:0] m_eff;
    logic [NW-1:0] n_eff;
    logic          started;
    logic          n_end;
    logic          at_end;

    // A zero length behaves as a one-cycle window dimension.
    assign m_eff   = (m_len == '0) ? MW'(1) : m_len;
    assign n_eff   = (n_len == '0) ? NW'(1) : n_len;
    assign started = (n_cnt_reg != '0);
    assign n_end   = started && (n_cnt_reg == n_sh_reg);
    assign at_end  = n_end && (m_cnt_reg == m_sh_reg);
    assign wrap    = run && at_end;

    always_ff @(posedge clk_ext or posedge rst) begin
        if (rst) begin
            m_cnt_reg <= '0;
            n_cnt_reg <= '0;
            m_sh_reg  <= '0;
            n_sh_reg  <= '0;
        end else if (clr) begin
            m_cnt_reg <= '0;
            n_cnt_reg <= '0;
        end else if (run) begin
            if (!started || at_end) begin
                m_cnt_reg <= MW'(1);
                n_cnt_reg <= NW'(1);
                m_sh_reg  <= m_eff;
                n_sh_reg  <= n_eff;
            end else if (n_end) begin
                n_cnt_reg <= NW'(1);
                m_cnt_reg <= m_cnt_reg + 1'b1;
            end else begin
                n_cnt_reg <= n_cnt_reg + 1'b1;
            end
        end
    end

    assign m_cnt = m_cnt_reg;
    assign n_cnt = n_cnt_reg;

endmodule

// File: rtl/dll_lock_ctrl.sv
// FMDLL lock sequencer: PD reset, SAR search then +/-1 tracking of the delay code,
// and a lock flag driven by direction alternations in tracking.
module dll_lock_ctrl
    import dll_pkg::*;
#(
    parameter int QW       = QW_DEF,
    parameter int MW       = MW_DEF,
    parameter int NW       = NW_DEF,
    parameter int LOCK_CNT = LOCK_CNT_DEF
) (
    input  logic          clk_ext,
    input  logic          Reset_DLL,
    input  logic          en,
    input  logic [MW-1:0] M,
    input  logic [NW-1:0] N,
    input  logic          COMP,
    output logic [MW-1:0] M_counter,
    output logic [NW-1:0] N_counter,
    output logic          Reset_PD,
    output logic [QW-1:0] Q,
    output logic [QW-1:0] Q_next,
    output logic          locked
);

    localparam int BW = $clog2(QW);
    localparam int AW = $clog2(LOCK_CNT + 1);
    localparam int PW = $clog2(PRST_CYC + 1);
    localparam logic [QW-1:0] Q_MAX = '1;

    dll_state_t    state_reg, state_next;
    logic [PW-1:0] prst_reg, prst_next;
    logic [BW-1:0] b_reg, b_next;
    logic [QW-1:0] q_reg, q_next;
    logic [QW-1:0] qn_reg, qn_next;
    logic [AW-1:0] alt_reg, alt_next;
    logic [AW-1:0] same_reg, same_next;
    logic          dir_reg, dir_next;
    logic          dir_vld_reg, dir_vld_next;
    logic          locked_reg, locked_next;
    logic          rpd_reg, rpd_next;
    logic          dec_pend_reg;

    logic          win_run;
    logic          win_wrap;
    logic          decide;
    logic [QW-1:0] q_upd;
    logic [QW-1:0] sar_bit;

    function automatic logic [QW-1:0] sat_inc(input logic [QW-1:0] v);
        return (v == Q_MAX) ? v : v + 1'b1;
    endfunction

    function automatic logic [QW-1:0] sat_dec(input logic [QW-1:0] v);
        return (v == '0) ? v : v - 1'b1;
    endfunction

    // One-hot mask of the next SAR bit (b-1).
    genvar gi;
    generate
        for (gi = 0; gi < QW; gi++) begin : g_sar_bit
            assign sar_bit[gi] = (b_reg == BW'(gi + 1));
        end
    endgenerate

    assign win_run = (state_next == SAR) || (state_next == TRACK);
    assign decide  = dec_pend_reg && en && ((state_reg == SAR) || (state_reg == TRACK));

    dll_win_cnt #(
        .MW(MW),
        .NW(NW)
    ) u_win_cnt (
        .clk_ext (clk_ext),
        .rst     (Reset_DLL),
        .clr     (!win_run),
        .run     (win_run),
        .m_len   (M),
        .n_len   (N),
        .m_cnt   (M_counter),
        .n_cnt   (N_counter),
        .wrap    (win_wrap)
    );

    always_comb begin
        state_next   = state_reg;
        prst_next    = prst_reg;
        b_next       = b_reg;
        q_next       = q_reg;
        qn_next      = qn_reg;
        alt_next     = alt_reg;
        same_next    = same_reg;
        dir_next     = dir_reg;
        dir_vld_next = dir_vld_reg;
        locked_next  = locked_reg;
        q_upd        = q_reg;

        if (!en) begin
            // Disable always wins, even over a pending decision.
            state_next   = IDLE;
            qn_next      = q_reg;
            locked_next  = 1'b0;
            alt_next     = '0;
            same_next    = '0;
            dir_vld_next = 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_next = PRST;
                    prst_next  = '0;
                end
                PRST: begin
                    if (prst_reg == PW'(PRST_CYC - 1)) begin
                        state_next = SAR;
                        q_next     = '0;
                        b_next     = BW'(QW - 1);
                        qn_next    = {1'b1, {(QW-1){1'b0}}};
                    end else begin
                        prst_next = prst_reg + 1'b1;
                    end
                end
                SAR: begin
                    if (decide) begin
                        q_upd  = COMP ? qn_reg : q_reg;
                        q_next = q_upd;
                        if (b_reg != '0) begin
                            b_next  = b_reg - 1'b1;
                            qn_next = q_upd | sar_bit;
                        end else begin
                            state_next   = TRACK;
                            qn_next      = sat_inc(q_upd);
                            alt_next     = '0;
                            same_next    = '0;
                            dir_vld_next = 1'b0;
                        end
                    end
                end
                TRACK: begin
                    if (decide) begin
                        q_upd   = COMP ? sat_inc(q_reg) : sat_dec(q_reg);
                        q_next  = q_upd;
                        qn_next = COMP ? sat_inc(q_upd) : sat_dec(q_upd);
                        if (dir_vld_reg && (COMP != dir_reg)) begin
                            alt_next  = (alt_reg == AW'(LOCK_CNT)) ? alt_reg : alt_reg + 1'b1;
                            same_next = AW'(1);
                        end else begin
                            alt_next  = '0;
                            same_next = (!dir_vld_reg) ? AW'(1) :
                                        (same_reg == AW'(LOCK_CNT)) ? same_reg : same_reg + 1'b1;
                        end
                        dir_next     = COMP;
                        dir_vld_next = 1'b1;
                        if (alt_next >= AW'(LOCK_CNT)) begin
                            locked_next = 1'b1;
                        end else if (same_next >= AW'(LOCK_CNT)) begin
                            locked_next = 1'b0;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end

        rpd_next = (state_next == IDLE) || (state_next == PRST);
    end

    always_ff @(posedge clk_ext or posedge Reset_DLL) begin
        if (Reset_DLL) begin
            state_reg    <= IDLE;
            prst_reg     <= '0;
            b_reg        <= BW'(QW - 1);
            q_reg        <= '0;
            qn_reg       <= '0;
            alt_reg      <= '0;
            same_reg     <= '0;
            dir_reg      <= 1'b0;
            dir_vld_reg  <= 1'b0;
            locked_reg   <= 1'b0;
            rpd_reg      <= 1'b1;
            dec_pend_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            prst_reg     <= prst_next;
            b_reg        <= b_next;
            q_reg        <= q_next;
            qn_reg       <= qn_next;
            alt_reg      <= alt_next;
            same_reg     <= same_next;
            dir_reg      <= dir_next;
            dir_vld_reg  <= dir_vld_next;
            locked_reg   <= locked_next;
            rpd_reg      <= rpd_next;
            dec_pend_reg <= win_wrap;
        end
    end

    assign Reset_PD = rpd_reg;
    assign Q        = q_reg;
    assign Q_next   = qn_reg;
    assign locked   = locked_reg;

endmodule
